greenpak_nvm_page_streamer: RTL and testbench
=============================================

GREENPAK_NVM_PAGE_STREAMER -- requirements
Module: greenpak_nvm_page_streamer

Interface
REQ-001 SHALL have parameters:
- PAGE_BYTES, default 16, data bytes per NVM page write.
- NUM_PAGES, default 16, pages per image (PAGE_BYTES*NUM_PAGES = 256).
- DEV_WR_BYTE, default 8'h14, I2C write address byte for the GreenPAK NVM block.
- WAIT_CYCLES, default 1000000, post-page NVM write-cycle delay in clk cycles (20 ms at 50 MHz).

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins programming.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse after last page wait completes.
- error  out  1  sticky NACK flag; cleared by reset or accepted start.
- rom_address  out  8  byte address to image ROM, registered.
- rom_chipselect  out  1  high while busy.
- rom_clken  out  1  constant 1.
- rom_readdata  in  8  ROM data; valid the cycle after rom_address is sampled.
- tx_data  out  8  byte to I2C byte master.
- tx_first  out  1  issue START before this byte.
- tx_last  out  1  issue STOP after this byte.
- tx_valid  out  1  byte offer.
- tx_ready  in  1  byte master accepts when tx_valid&tx_ready.
- tx_ack_valid  in  1  byte master reports ACK status of a previously accepted byte.
- tx_nack  in  1  qualified by tx_ack_valid; 1 = slave NACKed.

Function
REQ-003 SHALL implement states IDLE, HDR_DEV, HDR_ADDR, FETCH, FETCH_WAIT, DATA, WAIT_WR, DONE.
REQ-004 IDLE: start accepted -> HDR_DEV; page=0, byte=0, error cleared, busy=1 next cycle; start in any other state SHALL be ignored.
REQ-005 HDR_DEV SHALL offer tx_data=DEV_WR_BYTE, tx_first=1, tx_last=0; on handshake -> HDR_ADDR.
REQ-006 HDR_ADDR SHALL offer tx_data=page*PAGE_BYTES (8-bit), tx_first=0, tx_last=0; on handshake -> FETCH.
REQ-007 FETCH SHALL drive rom_address=page*PAGE_BYTES+byte for one cycle -> FETCH_WAIT -> capture rom_readdata into a holding register on FETCH_WAIT's exit edge -> DATA; ROM-to-byte latency exactly 2 cycles.
REQ-008 DATA SHALL offer the held byte, tx_last=1 when byte==PAGE_BYTES-1; tx_data held stable while tx_valid&~tx_ready.
REQ-009 DATA handshake SHALL go to FETCH with byte+1 when not last, else to WAIT_WR with byte=0 and wait counter loaded with WAIT_CYCLES-1.
REQ-010 WAIT_WR SHALL count down to 0, then go to HDR_DEV with page+1, or to DONE if page==NUM_PAGES-1.
REQ-011 DONE SHALL pulse done for exactly one cycle, drop busy that same cycle, and return to IDLE.
REQ-012 tx_valid SHALL be high only in HDR_DEV, HDR_ADDR, DATA; tx_first/tx_last SHALL be 0 whenever tx_valid=0.
REQ-013 tx_ack_valid&tx_nack in any busy state SHALL set error, force IDLE next cycle with busy=0 and no done pulse; NACK in IDLE SHALL be ignored.
REQ-014 NACK coinciding with a tx handshake SHALL take priority; the handshake's state advance is discarded.
REQ-015 Counters SHALL be sized to parameters; byte address arithmetic SHALL wrap modulo 256.

Reset
REQ-016 reset SHALL force IDLE and clear page, byte and wait counters; busy=0, done=0, error=0, tx_valid=0, tx_first=0, tx_last=0, rom_address=0, rom_chipselect=0, tx_data=0.
REQ-017 reset mid-transfer SHALL abort with no done pulse; a start in the reset cycle SHALL be ignored.

Verification
REQ-018 Full run, ROM[i]=i, tx_ready=1, WAIT_CYCLES=10:
- 16 frames of 18 bytes each: 0x14 (first), page*16, then data page*16..page*16+15 (last on final byte).
- Done pulses once; busy low afterwards.
REQ-019 Backpressure: tx_ready toggled pseudo-randomly -> identical byte sequence, tx_data stable while stalled, no byte dropped or duplicated.
REQ-020 NACK: tx_ack_valid&tx_nack on page 3 address byte -> error=1, busy=0 next cycle, no done; a subsequent start clears error and restarts at page 0.
REQ-021 Wait timing: last data handshake of page 0 to HDR_DEV offer of page 1 = WAIT_CYCLES+1 cycles.
REQ-022 Reset during page 7 DATA -> all outputs at reset values next cycle; a later start begins at page 0.
REQ-023 start pulsed while busy -> sequence unaffected; exactly one done.

Source files
------------

// File: rtl/greenpak_nvm_page_streamer.sv
// Streams a ROM image into GreenPAK NVM one page per I2C write frame.
// Each frame is: device write byte (START), page start address, then
// PAGE_BYTES data bytes (STOP after the last). After every frame the
// block idles WAIT_CYCLES clocks so the NVM write cycle can finish.
//
// Byte channel handshake: a byte transfers on any rising edge where
// tx_valid and tx_ready are both high. While tx_valid is high and
// tx_ready is low, tx_data/tx_first/tx_last are held stable. ACK status
// arrives separately on tx_ack_valid/tx_nack; a NACK while busy aborts
// the run and beats any handshake seen on the same edge.
module greenpak_nvm_page_streamer #(
    parameter int         PAGE_BYTES  = 16,
    parameter int         NUM_PAGES   = 16,
    parameter logic [7:0] DEV_WR_BYTE = 8'h14,
    parameter int         WAIT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rom_address,
    output logic       rom_chipselect,
    output logic       rom_clken,
    input  logic [7:0] rom_readdata,
    output logic [7:0] tx_data,
    output logic       tx_first,
    output logic       tx_last,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       tx_ack_valid,
    input  logic       tx_nack
);

    localparam int BYTE_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR_DEV,
        HDR_ADDR,
        FETCH,
        FETCH_WAIT,
        DATA,
        WAIT_WR,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [PAGE_W-1:0]   page, page_n;
    logic [BYTE_W-1:0]   byte_idx, byte_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic [7:0]          hold, hold_n;
    logic [7:0]          addr_n;
    logic                error_n;
    logic [7:0]          page_base;
    logic                last_byte;
    logic                handshake;
    logic                nack;

    // First ROM byte of the current page; wraps modulo 256.
    assign page_base = 8'(32'(page) * 32'(PAGE_BYTES));
    assign last_byte = (byte_idx == BYTE_W'(PAGE_BYTES - 1));

    assign busy           = (state != IDLE) && (state != DONE);
    assign done           = (state == DONE);
    assign rom_chipselect = busy;
    assign rom_clken      = 1'b1;

    assign tx_valid  = (state == HDR_DEV) || (state == HDR_ADDR) || (state == DATA);
    assign tx_first  = (state == HDR_DEV);
    assign tx_last   = (state == DATA) && last_byte;
    assign handshake = tx_valid && tx_ready;
    assign nack      = tx_ack_valid && tx_nack && busy;

    // Select the byte offered to the I2C byte master for the current state.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            HDR_DEV:  tx_data = DEV_WR_BYTE;
            HDR_ADDR: tx_data = page_base;
            DATA:     tx_data = hold;
            default:  tx_data = 8'h00;
        endcase
    end

    // Next-state and datapath updates; an in-flight NACK overrides everything.
    always_comb begin
        state_n = state;
        page_n  = page;
        byte_n  = byte_idx;
        wait_n  = wait_cnt;
        hold_n  = hold;
        addr_n  = rom_address;
        error_n = error;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = HDR_DEV;
                    page_n  = '0;
                    byte_n  = '0;
                    error_n = 1'b0;
                end
            end
            HDR_DEV: begin
                if (handshake) state_n = HDR_ADDR;
            end
            HDR_ADDR: begin
                if (handshake) begin
                    state_n = FETCH;
                    byte_n  = '0;
                    addr_n  = page_base;
                end
            end
            FETCH: begin
                state_n = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                // ROM output is valid now; latch it as this edge leaves the state.
                hold_n  = rom_readdata;
                state_n = DATA;
            end
            DATA: begin
                if (handshake) begin
                    if (last_byte) begin
                        state_n = WAIT_WR;
                        byte_n  = '0;
                        wait_n  = WAIT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_n = FETCH;
                        byte_n  = byte_idx + BYTE_W'(1);
                        addr_n  = page_base + 8'(byte_idx + BYTE_W'(1));
                    end
                end
            end
            WAIT_WR: begin
                if (wait_cnt == '0) begin
                    if (page == PAGE_W'(NUM_PAGES - 1)) begin
                        state_n = DONE;
                    end else begin
                        page_n  = page + PAGE_W'(1);
                        state_n = HDR_DEV;
                    end
                end else begin
                    wait_n = wait_cnt - WAIT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (nack) begin
            error_n = 1'b1;
            state_n = IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            page        <= '0;
            byte_idx    <= '0;
            wait_cnt    <= '0;
            hold        <= 8'h00;
            error       <= 1'b0;
            rom_address <= 8'h00;
        end else begin
            state       <= state_n;
            page        <= page_n;
            byte_idx    <= byte_n;
            wait_cnt    <= wait_n;
            hold        <= hold_n;
            error       <= error_n;
            rom_address <= addr_n;
        end
    end

endmodule

// File: tb/tb_greenpak_nvm_page_streamer.sv
// Bench for greenpak_nvm_page_streamer: a registered ROM model, a
// randomised tx_ready source, and a frame-level reference that lists the
// byte stream an image must produce.
module tb_greenpak_nvm_page_streamer;

    localparam int         PB  = 16;
    localparam int         NP  = 16;
    localparam int         WC  = 10;
    localparam logic [7:0] DEV = 8'h14;
    localparam int         FRAME = PB + 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] rom_address;
    logic       rom_chipselect;
    logic       rom_clken;
    logic [7:0] rom_readdata;
    logic [7:0] tx_data;
    logic       tx_first;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_ack_valid;
    logic       tx_nack;

    greenpak_nvm_page_streamer #(
        .PAGE_BYTES (PB),
        .NUM_PAGES  (NP),
        .DEV_WR_BYTE(DEV),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .rom_address   (rom_address),
        .rom_chipselect(rom_chipselect),
        .rom_clken     (rom_clken),
        .rom_readdata  (rom_readdata),
        .tx_data       (tx_data),
        .tx_first      (tx_first),
        .tx_last       (tx_last),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_ack_valid  (tx_ack_valid),
        .tx_nack       (tx_nack)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:255];
    int         n_checks = 0;
    int         n_errors = 0;
    int         hs_count = 0;
    int         done_count = 0;
    int         extra_cnt = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         ready_mode = 1'b0;
    bit         prev_stall = 1'b0;
    logic [9:0] held_word = '0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Registered image ROM: data appears the cycle after the address is sampled.
    always @(posedge clk) begin
        rom_readdata <= rom_mem[rom_address];
        cyc <= cyc + 1;
    end

    // Randomised byte-master readiness.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: match every accepted byte and watch channel invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!tx_valid) begin
                check("idle_first", 32'(tx_first), 32'd0);
                check("idle_last", 32'(tx_last), 32'd0);
            end
            if (prev_stall && tx_valid)
                check("stall_hold", 32'({tx_first, tx_last, tx_data}), 32'(held_word));
            check("cs_busy", 32'(rom_chipselect), 32'(busy));
            if (tx_valid && tx_ready) begin
                hs_count++;
                if (exp_q.size() == 0) extra_cnt++;
                else check("byte", 32'({tx_first, tx_last, tx_data}), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            held_word  = {tx_first, tx_last, tx_data};
            if (done) begin
                done_count++;
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Reference stream for a whole image: frame per page, STOP on last byte.
    task automatic build_expected();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            exp_q.push_back({1'b1, 1'b0, DEV});
            exp_q.push_back({2'b00, 8'((p * PB) % 256)});
            for (int b = 0; b < PB; b++)
                exp_q.push_back({1'b0, (b == PB - 1), rom_mem[(p * PB + b) % 256]});
        end
    endtask

    task automatic fill_rom(input bit identity);
        for (int i = 0; i < 256; i++)
            rom_mem[i] = identity ? 8'(i) : 8'($urandom_range(0, 255));
    endtask

    task automatic start_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("error_after_start", 32'(error), 32'd0);
    endtask

    task automatic wait_hs(input int target);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            if (hs_count >= target) break;
        end
        check("hs_reached", 32'(hs_count >= target), 32'd1);
    endtask

    task automatic wait_done(input bit spam, input int base);
        int d0;
        d0 = done_count;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            start = spam && ($urandom_range(0, 15) == 0);
            @(negedge clk); #1;
            if (done_count != d0) break;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("done_once", 32'(done_count - d0), 32'd1);
        check("stream_left", 32'(exp_q.size()), 32'd0);
        check("byte_count", 32'(hs_count - base), 32'(NP * FRAME));
        check("extra_bytes", 32'(extra_cnt), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        extra_cnt = 0;
    endtask

    // Directed scenarios with randomised contents and backpressure.
    initial begin
        int base;
        int t0;
        int d0;
        reset = 1'b1; start = 1'b0; tx_ack_valid = 1'b0; tx_nack = 1'b0;
        fill_rom(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_addr", 32'(rom_address), 32'd0);
        check("rst_cs", 32'(rom_chipselect), 32'd0);
        check("clken", 32'(rom_clken), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        mon_en = 1'b1;

        // Full identity image, ready always high, measure inter-page wait.
        build_expected();
        base = hs_count;
        start_run();
        wait_hs(base + FRAME);
        t0 = cyc;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (tx_valid && tx_first) break;
        end
        check("wait_gap", 32'(cyc - t0), 32'(WC + 1));
        wait_done(1'b0, base);

        // Random image under random backpressure and stray start pulses.
        fill_rom(1'b0);
        ready_mode = 1'b1;
        build_expected();
        base = hs_count;
        start_run();
        wait_done(1'b1, base);

        // NACK on page 3 address byte.
        ready_mode = 1'b0;
        fill_rom(1'b0);
        build_expected();
        base = hs_count;
        d0 = done_count;
        start_run();
        wait_hs(base + 3 * FRAME + 1);
        @(posedge clk); #1 tx_ack_valid = 1'b1; tx_nack = 1'b1;
        @(posedge clk); #1 tx_ack_valid = 1'b0; tx_nack = 1'b0;
        @(negedge clk); #1;
        check("nack_error", 32'(error), 32'd1);
        check("nack_busy", 32'(busy), 32'd0);
        check("nack_valid", 32'(tx_valid), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("nack_bytes", 32'(hs_count - base), 32'(3 * FRAME + 2));
        check("nack_no_done", 32'(done_count - d0), 32'd0);
        exp_q.delete();
        extra_cnt = 0;
        @(posedge clk); #1 tx_ack_valid = 1'b1; tx_nack = 1'b1;
        @(posedge clk); #1 tx_ack_valid = 1'b0; tx_nack = 1'b0;
        @(negedge clk); #1;
        check("idle_nack_error", 32'(error), 32'd1);
        check("idle_nack_busy", 32'(busy), 32'd0);
        build_expected();
        base = hs_count;
        start_run();
        wait_done(1'b0, base);

        // Reset during page 7 data, with start asserted in the reset cycle.
        ready_mode = 1'b1;
        fill_rom(1'b0);
        build_expected();
        base = hs_count;
        d0 = done_count;
        start_run();
        wait_hs(base + 7 * FRAME + 4);
        @(posedge clk); #1 reset = 1'b1; start = 1'b1;
        @(posedge clk); #1 reset = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_error", 32'(error), 32'd0);
        check("ar_valid", 32'(tx_valid), 32'd0);
        check("ar_flags", 32'({tx_first, tx_last}), 32'd0);
        check("ar_data", 32'(tx_data), 32'd0);
        check("ar_addr", 32'(rom_address), 32'd0);
        check("ar_cs", 32'(rom_chipselect), 32'd0);
        exp_q.delete();
        extra_cnt = 0;
        repeat (4) @(negedge clk);
        #1;
        check("ar_still_idle", 32'(busy), 32'd0);
        check("ar_no_done", 32'(done_count - d0), 32'd0);
        ready_mode = 1'b0;
        build_expected();
        base = hs_count;
        start_run();
        wait_done(1'b1, base);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
